// File: rtl/wb_load_stage.sv
// Write-back stage: commits ALU results and variable-latency load data.
// Ports: MEM inputs, data-memory response, reg-file write, freeze/hazard.
//
// Ports
//   clk, rst             clock; async active-low reset
//   mem_valid            MEM presents an instruction
//   wb_enable_in         instruction writes a register
//   mem_read_in          instruction is a load
//   alu_result_in        non-load write data
//   dest_in              destination register
//   mem_rdata            load data from data memory
//   mem_rdata_valid      load data valid (one pulse per load)
//   reg_file_wb_*        register-file write port (data, address, enable)
//   freeze               stall MEM and earlier stages
//   wb_pending_valid     a write is outstanding or committing
//   wb_pending_dest      destination of that write
//   load_timeout         pulse when a load is abandoned
module wb_load_stage #(
  parameter int REGISTER_LEN    = 32,
  parameter int REG_ADDRESS_LEN = 4,
  parameter int LOAD_TIMEOUT    = 255,
  parameter int TIMER_LEN       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  input  logic                       wb_enable_in,
  input  logic                       mem_read_in,
  input  logic [REGISTER_LEN-1:0]    alu_result_in,
  input  logic [REG_ADDRESS_LEN-1:0] dest_in,
  input  logic [REGISTER_LEN-1:0]    mem_rdata,
  input  logic                       mem_rdata_valid,
  output logic [REGISTER_LEN-1:0]    reg_file_wb_data,
  output logic [REG_ADDRESS_LEN-1:0] reg_file_wb_address,
  output logic                       reg_file_wb_en,
  output logic                       freeze,
  output logic                       wb_pending_valid,
  output logic [REG_ADDRESS_LEN-1:0] wb_pending_dest,
  output logic                       load_timeout
);

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } state_t;

  localparam logic [TIMER_LEN-1:0] TMAX =
    TIMER_LEN'(LOAD_TIMEOUT - 1);

  state_t                     state;
  state_t                     state_n;
  logic [TIMER_LEN-1:0]       timer;
  logic [TIMER_LEN-1:0]       timer_n;
  logic [REG_ADDRESS_LEN-1:0] ldest;
  logic [REG_ADDRESS_LEN-1:0] ldest_n;
  logic [REGISTER_LEN-1:0]    wdata_n;
  logic [REG_ADDRESS_LEN-1:0] waddr_n;
  logic                       wen_n;
  logic                       tout_n;
  logic                       accept;
  logic                       expired;

  assign accept  = mem_valid & wb_enable_in;
  assign expired = (timer == TMAX);

  always_comb begin
    state_n = state;
    timer_n = timer;
    ldest_n = ldest;
    wen_n   = 1'b0;
    tout_n  = 1'b0;
    wdata_n = reg_file_wb_data;
    waddr_n = reg_file_wb_address;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            !mem_read_in: begin
              wen_n   = 1'b1;
              wdata_n = alu_result_in;
              waddr_n = dest_in;
            end
            mem_read_in && mem_rdata_valid: begin
              // zero-wait load bypasses WAIT_LOAD
              wen_n   = 1'b1;
              wdata_n = mem_rdata;
              waddr_n = dest_in;
            end
            mem_read_in && !mem_rdata_valid: begin
              state_n = WAIT_LOAD;
              timer_n = '0;
              ldest_n = dest_in;
            end
            default: ;
          endcase
        end
      end
      WAIT_LOAD: begin
        // saturating: never wraps past the abandon point
        timer_n = expired ? timer : timer + 1'b1;
        unique case (1'b1)
          mem_rdata_valid: begin
            // data beats a coincident timeout
            state_n = IDLE;
            wen_n   = 1'b1;
            wdata_n = mem_rdata;
            waddr_n = ldest;
          end
          !mem_rdata_valid && expired: begin
            state_n = IDLE;
            tout_n  = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      timer               <= '0;
      ldest               <= '0;
      reg_file_wb_en      <= 1'b0;
      reg_file_wb_data    <= '0;
      reg_file_wb_address <= '0;
      load_timeout        <= 1'b0;
    end else begin
      state               <= state_n;
      timer               <= timer_n;
      ldest               <= ldest_n;
      reg_file_wb_en      <= wen_n;
      reg_file_wb_data    <= wdata_n;
      reg_file_wb_address <= waddr_n;
      load_timeout        <= tout_n;
    end
  end

  assign freeze = (state == WAIT_LOAD);

  assign wb_pending_valid = freeze | reg_file_wb_en;

  always_comb begin
    wb_pending_dest = '0;
    if (freeze)
      wb_pending_dest = ldest;
    else if (reg_file_wb_en)
      wb_pending_dest = reg_file_wb_address;
  end

endmodule
